// File: rtl/trigger_pkg.sv
// Shared types for the scope trigger/capture engine.
package trigger_pkg;
  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    WAIT = 3'd2,
    POST = 3'd3,
    DONE = 3'd4
  } trig_state_t;

  typedef enum logic [1:0] {
    NORMAL = 2'd0,
    SINGLE = 2'd1,
    AUTO   = 2'd2
  } trig_mode_t;

  typedef enum logic {
    RISE = 1'b0,
    FALL = 1'b1
  } edge_t;
endpackage

// File: rtl/trigger_schmitt.sv
// Hysteretic edge detector: arm_flag is set once din leaves the hysteresis band,
// fire pulses when the armed signal then crosses the level.
module trigger_schmitt
  import trigger_pkg::*;
#(
  parameter int DW = 12
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          tick,
  input  logic          track,
  input  logic          eval,
  input  logic          clear,
  input  logic [DW-1:0] din,
  input  logic [DW-1:0] level,
  input  logic [DW-1:0] hyst,
  input  logic          edge_sel,
  output logic          fire
);

  function automatic logic [DW-1:0] sat_sub(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] d;
    d = {1'b0, a} - {1'b0, b};
    return d[DW] ? '0 : d[DW-1:0];
  endfunction

  function automatic logic [DW-1:0] sat_add(input logic [DW-1:0] a, input logic [DW-1:0] b);
    logic [DW:0] s;
    s = {1'b0, a} + {1'b0, b};
    return s[DW] ? '1 : s[DW-1:0];
  endfunction

  logic          arm_flag;
  logic [DW-1:0] lo_thr;
  logic [DW-1:0] hi_thr;
  logic          set_cond;
  logic          fire_cond;

  assign lo_thr    = sat_sub(level, hyst);
  assign hi_thr    = sat_add(level, hyst);
  assign set_cond  = (edge_sel == FALL) ? (din > hi_thr) : (din < lo_thr);
  assign fire_cond = (edge_sel == FALL) ? (din <= level) : (din >= level);
  assign fire      = tick && eval && arm_flag && fire_cond;

  // Band tracking runs through PRE so an early excursion already arms the detector.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      arm_flag <= 1'b0;
    end else if (tick && track) begin
      if (fire) begin
        arm_flag <= 1'b0;
      end else if (set_cond) begin
        arm_flag <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/trigger_capture.sv
// Decimating scope trigger with pre-trigger ring buffer capture and
// NORMAL/SINGLE/AUTO re-arm behaviour; buffer read back by index after done.
module trigger_capture
  import trigger_pkg::*;
#(
  parameter int DW         = 12,
  parameter int DEPTH      = 256,
  parameter int DECIM_W    = 16,
  parameter int AUTO_TICKS = 4096,
  localparam int AW        = $clog2(DEPTH)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [DW-1:0]      din,
  input  logic [DW-1:0]      level,
  input  logic [DW-1:0]      hyst,
  input  logic               edge_sel,
  input  logic [1:0]         mode,
  input  logic [DECIM_W-1:0] decim,
  input  logic [AW-1:0]      pretrig,
  input  logic               arm,
  input  logic               ack,
  input  logic [AW-1:0]      rd_addr,
  output logic [DW-1:0]      rd_data,
  output logic               busy,
  output logic               done,
  output logic               forced,
  output logic [2:0]         state
);

  localparam int TW = $clog2(AUTO_TICKS + 1);

  trig_state_t        st;
  logic [DECIM_W-1:0] div_cnt;
  logic               tick;
  logic [DW-1:0]      level_q;
  logic [DW-1:0]      hyst_q;
  logic               edge_q;
  logic [1:0]         mode_q;
  logic [AW-1:0]      pretrig_q;
  logic [AW-1:0]      post_len;
  logic [AW-1:0]      wp;
  logic [AW-1:0]      start;
  logic [AW-1:0]      cnt;
  logic [AW-1:0]      rd_idx;
  logic [TW-1:0]      auto_cnt;
  logic               fire;
  logic               timeout;
  logic               we;
  logic               restart;
  logic [DW-1:0]      mem [DEPTH];

  // ">=" keeps the divider from running away if decim is lowered mid-count.
  assign tick = (div_cnt >= decim);

  always_ff @(posedge clk) begin
    if (rst || tick) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (arm) begin
      level_q   <= level;
      hyst_q    <= hyst;
      edge_q    <= edge_sel;
      mode_q    <= mode;
      pretrig_q <= pretrig;
    end
  end

  // DEPTH-1-pretrig equals the bitwise complement in AW bits.
  assign post_len = ~pretrig_q;
  assign timeout  = (mode_q == AUTO) && (auto_cnt == TW'(AUTO_TICKS - 1));
  assign we       = tick && (st == PRE || st == WAIT || st == POST);
  assign restart  = arm || (ack && st == DONE && mode_q != SINGLE);
  assign state    = st;

  trigger_schmitt #(.DW(DW)) u_schmitt (
    .clk      (clk),
    .rst      (rst),
    .tick     (tick),
    .track    (st == PRE || st == WAIT),
    .eval     (st == WAIT),
    .clear    (restart),
    .din      (din),
    .level    (level_q),
    .hyst     (hyst_q),
    .edge_sel (edge_q),
    .fire     (fire)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= IDLE;
      busy     <= 1'b0;
      done     <= 1'b0;
      forced   <= 1'b0;
      cnt      <= '0;
      auto_cnt <= '0;
      start    <= '0;
    end else if (arm) begin
      st       <= (pretrig == '0) ? WAIT : PRE;
      busy     <= 1'b1;
      done     <= 1'b0;
      forced   <= 1'b0;
      cnt      <= '0;
      auto_cnt <= '0;
    end else begin
      case (st)
        PRE: if (tick) begin
          cnt <= cnt + 1'b1;
          if (cnt == pretrig_q - 1'b1) st <= WAIT;
        end
        WAIT: if (tick) begin
          if (fire || timeout) begin
            start  <= wp - pretrig_q;
            forced <= !fire;
            cnt    <= '0;
            if (post_len == '0) begin
              st   <= DONE;
              busy <= 1'b0;
              done <= 1'b1;
            end else begin
              st <= POST;
            end
          end else begin
            auto_cnt <= auto_cnt + 1'b1;
          end
        end
        POST: if (tick) begin
          cnt <= cnt + 1'b1;
          if (cnt == post_len - 1'b1) begin
            st   <= DONE;
            busy <= 1'b0;
            done <= 1'b1;
          end
        end
        DONE: if (ack) begin
          done     <= 1'b0;
          cnt      <= '0;
          auto_cnt <= '0;
          if (mode_q == SINGLE) begin
            st <= IDLE;
          end else begin
            st   <= (pretrig_q == '0) ? WAIT : PRE;
            busy <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wp <= '0;
    end else if (we) begin
      wp <= wp + 1'b1;
    end
  end

  // Ring RAM: synchronous write, registered read rebased to the capture start.
  always_ff @(posedge clk) begin
    if (we) mem[wp] <= din;
  end

  assign rd_idx = start + rd_addr;

  always_ff @(posedge clk) begin
    if (rst) begin
      rd_data <= '0;
    end else begin
      rd_data <= mem[rd_idx];
    end
  end

endmodule

// File: tb/tb_trigger_capture.sv
// Randomized bench for trigger_capture: records every sample fed after arm and
// derives trigger point, done timing and buffer contents from the trigger rules.
`timescale 1ns/1ps
module tb_trigger_capture;
  localparam int DW = 12, DEPTH = 256, DECIM_W = 16, AUTO_TICKS = 16, AW = 8;
  localparam int S_IDLE = 0, S_PRE = 1, S_WAIT = 2, S_POST = 3, S_DONE = 4;

  logic               clk = 1'b0;
  logic               rst;
  logic [DW-1:0]      din, level, hyst, rd_data;
  logic               edge_sel, arm, ack, busy, done, forced;
  logic [1:0]         mode;
  logic [DECIM_W-1:0] decim;
  logic [AW-1:0]      pretrig, rd_addr;
  logic [2:0]         state;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  trigger_capture #(.DW(DW), .DEPTH(DEPTH), .DECIM_W(DECIM_W), .AUTO_TICKS(AUTO_TICKS)) dut (
    .clk(clk), .rst(rst), .din(din), .level(level), .hyst(hyst), .edge_sel(edge_sel),
    .mode(mode), .decim(decim), .pretrig(pretrig), .arm(arm), .ack(ack), .rd_addr(rd_addr),
    .rd_data(rd_data), .busy(busy), .done(done), .forced(forced), .state(state)
  );

  function automatic int gen(input int pat, input int k, input int lv);
    int v;
    int p;
    case (pat)
      0: v = (k * 8 > 4095) ? 4095 : k * 8;
      1: v = (k == 150) ? 2000 : 2044 + int'($urandom_range(8, 0));
      2: begin
        p = k % 256;
        v = (p < 128) ? p * 32 : (255 - p) * 32;
      end
      3: v = 100;
      default: begin
        v = lv - 200 + int'($urandom_range(399, 0));
        if (v < 0) v = 0;
        if (v > 4095) v = 4095;
      end
    endcase
    return v;
  endfunction

  // kind: 0 = arm, 1 = ack, 2 = arm and ack together
  task automatic run_capture(input int kind, input int pat, input int ed, input int md,
                             input int lv, input int hy, input int pt, input string nm);
    int hist[$];
    int k, t, lo, hi, exp_w, idx, v;
    bit flag, frc, f, to;
    @(negedge clk);
    edge_sel = ed[0]; mode = md[1:0]; level = DW'(lv); hyst = DW'(hy); pretrig = AW'(pt);
    arm = (kind != 1); ack = (kind != 0);
    @(negedge clk);
    arm = 1'b0; ack = 1'b0;
    checks++;
    if (state !== 3'((pt == 0) ? S_WAIT : S_PRE) || done !== 1'b0) begin
      errors++;
      $display("FAIL %s_start: state=%0d done=%0d, expected state=%0d done=0",
               nm, state, done, (pt == 0) ? S_WAIT : S_PRE);
    end
    k = 0;
    forever begin
      v = gen(pat, k, lv);
      din = DW'(v);
      hist.push_back(v);
      k++;
      @(negedge clk);
      if (done === 1'b1 || k > 3000) break;
    end
    lo = (lv - hy < 0) ? 0 : lv - hy;
    hi = (lv + hy > 4095) ? 4095 : lv + hy;
    t = -1; flag = 0; frc = 0;
    for (int i = 0; i < hist.size(); i++) begin
      if (i >= pt) begin
        f  = flag && ((ed == 0) ? (hist[i] >= lv) : (hist[i] <= lv));
        to = (md == 2) && (i - pt + 1 == AUTO_TICKS);
        if (f || to) begin
          t = i; frc = !f;
          break;
        end
      end
      if ((ed == 0) ? (hist[i] < lo) : (hist[i] > hi)) flag = 1;
    end
    exp_w = t + DEPTH - pt;
    checks++;
    if (t < 0 || k != exp_w || done !== 1'b1) begin
      errors++;
      $display("FAIL %s_done: samples=%0d done=%0d, expected samples=%0d done=1 (trigger idx %0d)",
               nm, k, done, exp_w, t);
    end
    checks++;
    if (forced !== frc || state !== 3'(S_DONE) || busy !== 1'b0) begin
      errors++;
      $display("FAIL %s_flags: forced=%0d state=%0d busy=%0d, expected forced=%0d state=%0d busy=0",
               nm, forced, state, busy, frc, S_DONE);
    end
    if (t >= 0) begin
      for (int a = 0; a < DEPTH; a++) begin
        rd_addr = AW'(a);
        @(negedge clk);
        idx = t - pt + a;
        checks++;
        if (idx >= hist.size() || rd_data !== DW'(hist[idx])) begin
          errors++;
          $display("FAIL %s_buf[%0d]: got %0d expected %0d", nm, a, rd_data,
                   (idx < hist.size()) ? hist[idx] : -1);
        end
      end
    end
  endtask

  task automatic test_reset();
    checks++;
    if (state !== 3'(S_IDLE) || busy !== 1'b0 || done !== 1'b0 || forced !== 1'b0 || rd_data !== '0) begin
      errors++;
      $display("FAIL reset: state=%0d busy=%0d done=%0d forced=%0d rd_data=%0d, expected all 0",
               state, busy, done, forced, rd_data);
    end
  endtask

  task automatic test_ramp();
    run_capture(0, 0, 0, 0, 2048, 8, 64, "ramp");
    rd_addr = AW'(64);
    @(negedge clk);
    checks++;
    if (rd_data < 2048) begin
      errors++;
      $display("FAIL ramp_trig_sample: got %0d expected >= 2048", rd_data);
    end
    rd_addr = AW'(63);
    @(negedge clk);
    checks++;
    if (rd_data >= 2048) begin
      errors++;
      $display("FAIL ramp_pre_sample: got %0d expected < 2048", rd_data);
    end
  endtask

  task automatic test_noise();
    run_capture(0, 1, 0, 0, 2048, 16, 64, "noise");
    repeat (300) begin
      @(negedge clk);
      din = DW'(2044 + int'($urandom_range(8, 0)));
    end
    checks++;
    if (state !== 3'(S_DONE) || done !== 1'b1) begin
      errors++;
      $display("FAIL noise_single_capture: state=%0d done=%0d expected state=%0d done=1",
               state, done, S_DONE);
    end
  endtask

  task automatic test_single_fall();
    run_capture(0, 2, 1, 1, 2048, 100, 32, "fall_single");
    @(negedge clk);
    ack = 1'b1;
    @(negedge clk);
    ack = 1'b0;
    checks++;
    if (state !== 3'(S_IDLE) || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_ack: state=%0d done=%0d busy=%0d expected state=0 done=0 busy=0",
               state, done, busy);
    end
    for (int k = 0; k < 300; k++) begin
      din = DW'(gen(2, k, 2048));
      @(negedge clk);
    end
    checks++;
    if (state !== 3'(S_IDLE) || done !== 1'b0) begin
      errors++;
      $display("FAIL single_idle_hold: state=%0d done=%0d expected state=0 done=0", state, done);
    end
  endtask

  task automatic test_auto();
    run_capture(0, 3, 0, 2, 2048, 8, 10, "auto_const");
  endtask

  task automatic test_random();
    int ed, md, lv, hy, pt;
    for (int i = 0; i < 3; i++) begin
      ed = int'($urandom_range(1, 0));
      md = ($urandom_range(1, 0) == 1) ? 2 : 0;
      lv = 1000 + int'($urandom_range(1999, 0));
      hy = int'($urandom_range(63, 0));
      pt = int'($urandom_range(DEPTH - 1, 0));
      run_capture(0, 4, ed, md, lv, hy, pt, "random");
    end
    run_capture(0, 4, 0, 2, 10, 50, 20, "sat_low");
    run_capture(0, 4, 1, 2, 4090, 50, 20, "sat_high");
  endtask

  task automatic test_back_to_back();
    run_capture(0, 4, 0, 3, 2048, 20, 0, "b2b_arm");
    run_capture(1, 4, 0, 3, 2048, 20, 0, "b2b_ack");
    run_capture(0, 4, 1, 0, 2048, 20, DEPTH - 1, "pretrig_max");
  endtask

  task automatic test_rst_arm_ack();
    int k;
    @(negedge clk);
    edge_sel = 1'b0; mode = 2'd0; level = DW'(2048); hyst = DW'(8); pretrig = AW'(4);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    k = 0;
    while (state !== 3'(S_POST) && k < 1000) begin
      din = DW'(gen(0, k, 2048));
      k++;
      @(negedge clk);
    end
    checks++;
    if (state !== 3'(S_POST)) begin
      errors++;
      $display("FAIL reach_post: state=%0d expected %0d", state, S_POST);
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checks++;
    if (state !== 3'(S_IDLE) || done !== 1'b0 || busy !== 1'b0 || forced !== 1'b0) begin
      errors++;
      $display("FAIL rst_in_post: state=%0d done=%0d busy=%0d forced=%0d expected all 0",
               state, done, busy, forced);
    end
    din = DW'(100); mode = 2'd0; pretrig = AW'(8);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    repeat (30) @(negedge clk);
    checks++;
    if (state !== 3'(S_WAIT) || busy !== 1'b1) begin
      errors++;
      $display("FAIL hold_wait: state=%0d busy=%0d expected state=%0d busy=1", state, busy, S_WAIT);
    end
    run_capture(0, 0, 0, 0, 2048, 8, 64, "rearm_in_wait");
    run_capture(2, 4, 1, 1, 2048, 30, 100, "arm_beats_ack");
  endtask

  task automatic test_decim();
    int n;
    @(negedge clk);
    decim = DECIM_W'(499); rst = 1'b1; din = DW'(100);
    level = DW'(2048); hyst = DW'(8); edge_sel = 1'b0; mode = 2'd1; pretrig = AW'(3);
    @(negedge clk);
    rst = 1'b0;
    repeat (99) @(negedge clk);
    arm = 1'b1;
    @(negedge clk);
    arm = 1'b0;
    n = 100;
    checks++;
    if (state !== 3'(S_PRE)) begin
      errors++;
      $display("FAIL decim_pre: state=%0d expected %0d", state, S_PRE);
    end
    while (state !== 3'(S_WAIT) && n < 3000) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n != 1500) begin
      errors++;
      $display("FAIL decim_rate: WAIT reached at clock %0d expected 1500", n);
    end
    decim = '0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; din = '0; level = '0; hyst = '0; edge_sel = 1'b0; mode = 2'd0;
    decim = '0; pretrig = '0; arm = 1'b0; ack = 1'b0; rd_addr = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_ramp();
    test_noise();
    test_single_fall();
    test_auto();
    test_random();
    test_back_to_back();
    test_rst_arm_ack();
    test_decim();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
